// File: rtl/ixc_gfifo_pkg.sv
// ixc_gfifo_pkg: shared types, header field positions and word builders for the global-FIFO collector
// Contents: MAGIC_DEF, header field LSB/MSB constants, ixc_gfifo_rec_t, ixc_gfifo_state_t,
//           hdr_word() and data_word() helpers.
package ixc_gfifo_pkg;
    localparam logic [7:0] MAGIC_DEF     = 8'hA5;
    localparam int         HDR_MAGIC_MSB = 63;
    localparam int         HDR_MAGIC_LSB = 56;
    localparam int         HDR_CLAMP_BIT = 32;
    localparam int         HDR_LEN_MSB   = 31;
    localparam int         HDR_LEN_LSB   = 20;
    localparam int         HDR_CBID_MSB  = 19;
    localparam int         HDR_CBID_LSB  = 0;
    localparam logic [11:0] MAX_BYTES    = 12'd64;

    typedef struct packed {
        logic [19:0]  cbid;
        logic [11:0]  len;
        logic         clamp;
        logic [511:0] data;
    } ixc_gfifo_rec_t;

    typedef enum logic [1:0] {IDLE, HDR, DATA} ixc_gfifo_state_t;

    function automatic logic [63:0] hdr_word(input logic [7:0] magic, input ixc_gfifo_rec_t r);
        logic [63:0] w;
        w = '0;
        w[HDR_MAGIC_MSB:HDR_MAGIC_LSB] = magic;
        w[HDR_CLAMP_BIT]               = r.clamp;
        w[HDR_LEN_MSB:HDR_LEN_LSB]     = r.len;
        w[HDR_CBID_MSB:HDR_CBID_LSB]   = r.cbid;
        return w;
    endfunction

    // Bytes at or beyond len are zeroed; only the final word of a record can contain such bytes.
    function automatic logic [63:0] data_word(input ixc_gfifo_rec_t r, input logic [2:0] idx);
        logic [63:0] w;
        w = r.data[64*idx +: 64];
        for (int k = 0; k < 8; k++)
            if ({6'd0, idx, 3'(k)} >= r.len) w[8*k +: 8] = 8'h00;
        return w;
    endfunction

    // Number of data words: ceil(len/8), len already clamped to 64.
    function automatic logic [3:0] nwords(input logic [11:0] len);
        logic [11:0] t;
        t = len + 12'd7;
        return t[6:3];
    endfunction
endpackage

// File: rtl/ixc_gfifo_collect_if.sv
// ixc_gfifo_collect_if: global-FIFO record bus plus the 64-bit upload stream
// master: record producer / stream consumer side; slave: the collector.
// Signals: GFtsReq, GFcbid[19:0], GFlen[11:0], GFidata[511:0], GFfull, ovalid, oready, odata[63:0], olast.
interface ixc_gfifo_collect_if;
    logic         GFtsReq;
    logic [19:0]  GFcbid;
    logic [11:0]  GFlen;
    logic [511:0] GFidata;
    logic         GFfull;
    logic         ovalid;
    logic         oready;
    logic [63:0]  odata;
    logic         olast;

    modport master (output GFtsReq, GFcbid, GFlen, GFidata, oready,
                    input  GFfull, ovalid, odata, olast);
    modport slave  (input  GFtsReq, GFcbid, GFlen, GFidata, oready,
                    output GFfull, ovalid, odata, olast);
endinterface

// File: rtl/ixc_gfifo_rbuf.sv
// ixc_gfifo_rbuf: synchronous DEPTH-entry record FIFO with registered count
// Ports: fclk, rstn (sync active-low), push/din, pop, head (oldest entry), head2 (entry after head),
//        count (registered occupancy), full (count==DEPTH).
module ixc_gfifo_rbuf
    import ixc_gfifo_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic           fclk,
    input  logic           rstn,
    input  logic           push,
    input  ixc_gfifo_rec_t din,
    input  logic           pop,
    output ixc_gfifo_rec_t head,
    output ixc_gfifo_rec_t head2,
    output logic [AW:0]    count,
    output logic           full
);
    ixc_gfifo_rec_t mem [DEPTH];
    logic [AW-1:0]  wptr, rptr;
    logic           wr, rd;

    assign full  = count == (AW+1)'(DEPTH);
    assign wr    = push & ~full;
    assign rd    = pop & (count != '0);
    assign head  = mem[rptr];
    // Lets the output stage load the next header on the same edge that pops the current record.
    assign head2 = mem[rptr + AW'(1)];

    always_ff @(posedge fclk)
        if (wr) mem[wptr] <= din;

    always_ff @(posedge fclk) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + AW'(1);
            if (rd) rptr <= rptr + AW'(1);
            count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
        end
    end
endmodule

// File: rtl/ixc_gfifo_collect.sv
// ixc_gfifo_collect: buffers global-FIFO records and serialises each into header + ceil(len/8) 64-bit words
// Ports: fclk, rstn (sync active-low), bus (slave: GF record input, GFfull backpressure,
//        ovalid/oready/odata/olast stream), ovf (sticky drop flag), drop_cnt (saturating drop count).
module ixc_gfifo_collect
    import ixc_gfifo_pkg::*;
#(
    parameter int         DEPTH = 4,
    parameter logic [7:0] MAGIC = MAGIC_DEF
) (
    input  logic                  fclk,
    input  logic                  rstn,
    ixc_gfifo_collect_if.slave    bus,
    output logic                  ovf,
    output logic [15:0]           drop_cnt
);
    localparam int AW = $clog2(DEPTH);

    ixc_gfifo_rec_t   wrec, head, head2;
    ixc_gfifo_state_t state;
    logic [AW:0]      count;
    logic             full, fire, pop;
    logic [2:0]       widx;
    logic [3:0]       nw;
    logic             ovalid, olast;
    logic [63:0]      odata;

    assign wrec.cbid  = bus.GFcbid;
    assign wrec.clamp = bus.GFlen > MAX_BYTES;
    assign wrec.len   = wrec.clamp ? MAX_BYTES : bus.GFlen;
    assign wrec.data  = bus.GFidata;

    assign fire = ovalid & bus.oready;
    // olast marks the final word of the record on display, so its handshake retires the entry.
    assign pop  = fire & olast;

    // One slot of headroom covers the port's registered view of GFfull.
    assign bus.GFfull = count >= (AW+1)'(DEPTH - 1);
    assign bus.ovalid = ovalid;
    assign bus.odata  = odata;
    assign bus.olast  = olast;

    ixc_gfifo_rbuf #(.DEPTH(DEPTH)) u_rbuf (
        .fclk  (fclk),
        .rstn  (rstn),
        .push  (bus.GFtsReq),
        .din   (wrec),
        .pop   (pop),
        .head  (head),
        .head2 (head2),
        .count (count),
        .full  (full)
    );

    always_ff @(posedge fclk) begin
        if (!rstn) begin
            state    <= IDLE;
            widx     <= '0;
            nw       <= '0;
            ovalid   <= 1'b0;
            odata    <= '0;
            olast    <= 1'b0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (bus.GFtsReq && full) begin
                ovf <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
            case (state)
                IDLE: if (count != '0) begin
                    state  <= HDR;
                    ovalid <= 1'b1;
                    odata  <= hdr_word(MAGIC, head);
                    olast  <= head.len == 12'd0;
                end
                HDR, DATA: if (fire) begin
                    if (olast) begin
                        // Next record follows without a bubble when one is already buffered.
                        if (count > (AW+1)'(1)) begin
                            state <= HDR;
                            odata <= hdr_word(MAGIC, head2);
                            olast <= head2.len == 12'd0;
                        end else begin
                            state  <= IDLE;
                            ovalid <= 1'b0;
                            odata  <= '0;
                            olast  <= 1'b0;
                        end
                    end else if (state == HDR) begin
                        state <= DATA;
                        widx  <= '0;
                        nw    <= nwords(head.len);
                        odata <= data_word(head, 3'd0);
                        olast <= nwords(head.len) == 4'd1;
                    end else begin
                        widx  <= widx + 3'd1;
                        odata <= data_word(head, widx + 3'd1);
                        olast <= {1'b0, widx} + 4'd2 == nw;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ixc_gfifo_collect.sv
// tb_ixc_gfifo_collect: directed self-checking bench for ixc_gfifo_collect
module tb_ixc_gfifo_collect;
    logic        fclk = 1'b0;
    logic        rstn;
    logic        ovf;
    logic [15:0] drop_cnt;
    int          checks = 0;
    int          failures = 0;

    ixc_gfifo_collect_if bus();

    ixc_gfifo_collect #(.DEPTH(4), .MAGIC(8'hA5)) dut (
        .fclk     (fclk),
        .rstn     (rstn),
        .bus      (bus),
        .ovf      (ovf),
        .drop_cnt (drop_cnt)
    );

    always #5 fclk = ~fclk;

    task automatic step();
        @(posedge fclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mkdata(input logic [7:0] base);
        logic [511:0] d;
        for (int k = 0; k < 64; k++) d[8*k +: 8] = base + 8'(k);
        return d;
    endfunction

    function automatic logic [63:0] expw(input logic [7:0] base, input int len, input int i);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = (8*i + k < len) ? base + 8'(8*i + k) : 8'h00;
        return w;
    endfunction

    function automatic logic [63:0] exph(input logic [19:0] cbid, input int len, input logic clamp);
        return {8'hA5, 23'h0, clamp, 12'(len), cbid};
    endfunction

    task automatic push(input logic [19:0] cbid, input logic [11:0] len, input logic [7:0] base);
        bus.GFtsReq = 1'b1;
        bus.GFcbid  = cbid;
        bus.GFlen   = len;
        bus.GFidata = mkdata(base);
        step();
        bus.GFtsReq = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [19:0] cbid, input int len, input logic clamp,
                        input logic [7:0] base, input bit stall, input bit more, input int exp_words);
        int          widx = 0;
        int          budget = 0;
        bit          done = 0;
        bit          held = 0;
        logic [63:0] hd;
        logic        hl;
        while (!done && budget < 400) begin
            if (held) begin
                chk({tag, "_hold_v"}, 64'(bus.ovalid), 64'(1));
                chk({tag, "_hold_d"}, bus.odata, hd);
                chk({tag, "_hold_l"}, 64'(bus.olast), 64'(hl));
            end
            bus.oready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.ovalid && bus.oready) begin
                chk($sformatf("%s_w%0d", tag, widx), bus.odata,
                    widx == 0 ? exph(cbid, len, clamp) : expw(base, len, widx - 1));
                chk($sformatf("%s_last%0d", tag, widx), 64'(bus.olast), 64'(widx == exp_words - 1));
                done = bus.olast;
                widx++;
                held = 0;
                step();
                budget++;
                if (!done) chk({tag, "_gap"}, 64'(bus.ovalid), 64'(1));
                else chk({tag, "_tail"}, 64'(bus.ovalid), 64'(more));
            end else begin
                held = bus.ovalid;
                hd = bus.odata;
                hl = bus.olast;
                step();
                budget++;
            end
        end
        chk({tag, "_done"}, 64'(done), 64'(1));
        chk({tag, "_words"}, 64'(widx), 64'(exp_words));
        bus.oready = 1'b0;
    endtask

    initial begin
        int seen;
        rstn        = 1'b0;
        bus.GFtsReq = 1'b0;
        bus.GFcbid  = '0;
        bus.GFlen   = '0;
        bus.GFidata = '0;
        bus.oready  = 1'b0;
        step();
        step();
        chk("rst_ovalid", 64'(bus.ovalid), 64'(0));
        chk("rst_odata", bus.odata, 64'h0);
        chk("rst_olast", 64'(bus.olast), 64'(0));
        chk("rst_gffull", 64'(bus.GFfull), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        chk("rst_drop", 64'(drop_cnt), 64'(0));
        rstn = 1'b1;
        step();

        bus.oready = 1'b1;
        push(20'h12345, 12'd13, 8'h00);
        chk("lat_edge0", 64'(bus.ovalid), 64'(0));
        step();
        chk("lat_edge1", 64'(bus.ovalid), 64'(1));
        chk("len13_hdr_const", bus.odata, 64'hA500000000D12345);
        recv("len13", 20'h12345, 13, 1'b0, 8'h00, 1'b0, 1'b0, 3);
        chk("len13_w1_const", expw(8'h00, 13, 1), 64'h0000000C0B0A0908);

        push(20'h00777, 12'd0, 8'h55);
        recv("len0", 20'h00777, 0, 1'b0, 8'h55, 1'b0, 1'b0, 1);
        step();
        chk("len0_empty", 64'(bus.GFfull), 64'(0));

        push(20'h00ABC, 12'd100, 8'h20);
        recv("clamp", 20'h00ABC, 64, 1'b1, 8'h20, 1'b0, 1'b0, 9);

        bus.oready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            bus.GFtsReq = 1'b1;
            bus.GFcbid  = 20'(i);
            bus.GFlen   = 12'd8;
            bus.GFidata = mkdata(8'(16 * i));
            step();
            chk($sformatf("bb_full%0d", i), 64'(bus.GFfull), 64'(i >= 3));
            chk($sformatf("bb_drop%0d", i), 64'(drop_cnt), 64'(i > 4 ? i - 4 : 0));
        end
        bus.GFtsReq = 1'b0;
        chk("bb_ovf", 64'(ovf), 64'(1));
        for (int i = 1; i <= 4; i++)
            recv($sformatf("bb_rec%0d", i), 20'(i), 8, 1'b0, 8'(16 * i), 1'b0, i < 4, 2);
        chk("bb_drop_final", 64'(drop_cnt), 64'(2));

        push(20'hA0001, 12'd64, 8'h40);
        push(20'hA0002, 12'd8, 8'h80);
        push(20'hA0003, 12'd1, 8'hC0);
        recv("st_a", 20'hA0001, 64, 1'b0, 8'h40, 1'b1, 1'b1, 9);
        recv("st_b", 20'hA0002, 8, 1'b0, 8'h80, 1'b1, 1'b1, 2);
        recv("st_c", 20'hA0003, 1, 1'b0, 8'hC0, 1'b1, 1'b0, 2);
        chk("st_ovf_sticky", 64'(ovf), 64'(1));

        bus.oready = 1'b1;
        push(20'hBEEF0, 12'd64, 8'h10);
        step();
        step();
        step();
        chk("mid_ovalid", 64'(bus.ovalid), 64'(1));
        chk("mid_olast", 64'(bus.olast), 64'(0));
        chk("mid_word1", bus.odata, expw(8'h10, 64, 1));
        rstn = 1'b0;
        step();
        chk("mrst_ovalid", 64'(bus.ovalid), 64'(0));
        chk("mrst_odata", bus.odata, 64'h0);
        chk("mrst_olast", 64'(bus.olast), 64'(0));
        chk("mrst_gffull", 64'(bus.GFfull), 64'(0));
        chk("mrst_ovf", 64'(ovf), 64'(0));
        chk("mrst_drop", 64'(drop_cnt), 64'(0));
        rstn = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.ovalid || bus.olast) seen++;
        end
        chk("mrst_flushed", 64'(seen), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
